// File: rtl/decode3to8_strobe_pkg.sv
// mcs8_pkg: shared state encoding, widths and one-hot helper for the MCS8 select-line path.
package mcs8_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LINES-1:0]  lines_t;

    function automatic lines_t onehot(input code_t c);
        return lines_t'(1) << c;
    endfunction

endpackage

// File: rtl/decode3to8_strobe_if.sv
// decode3to8_strobe_if: code handshake, abort and strobe outputs of the select-line decoder.
interface decode3to8_strobe_if;
    import mcs8_pkg::*;

    logic   In_Valid;
    code_t  In_Code;
    logic   In_Ready;
    logic   Abort;
    lines_t Out;
    logic   Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7;
    logic   Busy;
    logic   Done;

    modport master (
        output In_Valid, In_Code, Abort,
        input  In_Ready, Out, Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7, Busy, Done
    );

    modport slave (
        input  In_Valid, In_Code, Abort,
        output In_Ready, Out, Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7, Busy, Done
    );

endinterface

// File: rtl/decode3to8_strobe_timer.sv
// strobe_timer: loadable 8-bit down-counter; clear beats load beats decrement, holds at zero.
module strobe_timer (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic       zero_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? 8'd0 :
                load_i ? load_val_i :
                (en_i && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/decode3to8_strobe.sv
// decode3to8_strobe: accepts a 3-bit line code and drives the matching select line
// high for PULSE_LEN cycles, then holds all lines low for GAP_LEN cycles.
module decode3to8_strobe
    import mcs8_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input logic Clk,
    input logic Rst_n,
    decode3to8_strobe_if.slave bus
);

    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse
        $error("decode3to8_strobe: PULSE_LEN must be 1..255");
    end
    if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap
        $error("decode3to8_strobe: GAP_LEN must be 0..255");
    end

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_LEN - 1);
    localparam logic       HAS_GAP    = (GAP_LEN != 0);

    logic [1:0] state_q, state_d;
    code_t      code_q;
    lines_t     out_q, out_d;
    logic       done_q, busy_q;
    logic       accept, zero, drive_end, gap_end;

    assign bus.In_Ready = (state_q == IDLE) & ~bus.Abort;
    assign accept       = bus.In_Valid & bus.In_Ready;
    assign drive_end    = (state_q == DRIVE) & zero;
    assign gap_end      = (state_q == GAP) & zero;

    strobe_timer u_timer (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .load_i     (accept | (drive_end & HAS_GAP)),
        .load_val_i (accept ? PULSE_LOAD : GAP_LOAD),
        .en_i       (state_q != IDLE),
        .clr_i      (bus.Abort),
        .zero_o     (zero)
    );

    // Out is derived from the next state so it can never be set outside DRIVE.
    always_comb begin
        state_d = bus.Abort ? IDLE :
                  accept    ? DRIVE :
                  drive_end ? (HAS_GAP ? GAP : IDLE) :
                  gap_end   ? IDLE : state_q;
        out_d   = (state_d == DRIVE) ? onehot(accept ? bus.In_Code : code_q) : '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) code_q <= bus.In_Code;
            out_q   <= out_d;
            done_q  <= drive_end & ~bus.Abort;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.Out  = out_q;
    assign bus.Out0 = out_q[0];
    assign bus.Out1 = out_q[1];
    assign bus.Out2 = out_q[2];
    assign bus.Out3 = out_q[3];
    assign bus.Out4 = out_q[4];
    assign bus.Out5 = out_q[5];
    assign bus.Out6 = out_q[6];
    assign bus.Out7 = out_q[7];
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule

// File: tb/tb_decode3to8_strobe.sv
// tb_decode3to8_strobe: directed checks of the strobe decoder at default timing and at PULSE_LEN=1/GAP_LEN=0.
module tb_decode3to8_strobe;

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp_out;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t vecs[8];

    always #5 Clk = ~Clk;

    decode3to8_strobe_if a();
    decode3to8_strobe_if b();

    decode3to8_strobe #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(a));
    decode3to8_strobe #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bits_a();
        return {a.Out7, a.Out6, a.Out5, a.Out4, a.Out3, a.Out2, a.Out1, a.Out0};
    endfunction

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        int n;
        vecs[0] = '{3'd0, 8'h01};
        vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04};
        vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10};
        vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40};
        vecs[7] = '{3'd7, 8'h80};
        a.In_Valid = 0; a.In_Code = 0; a.Abort = 0;
        b.In_Valid = 0; b.In_Code = 0; b.Abort = 0;

        #3;
        chk("rst_out", a.Out, 8'h00);
        chk("rst_busy", a.Busy, 0);
        chk("rst_done", a.Done, 0);
        chk("rst_ready", a.In_Ready, 1);
        @(negedge Clk);
        Rst_n = 1;
        cyc();

        // single strobe of code 5
        a.In_Code = 3'd5; a.In_Valid = 1;
        #1 chk("t1_ready", a.In_Ready, 1);
        cyc();
        a.In_Valid = 0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_out", a.Out, 8'h20);
            chk("t1_out5", a.Out5, 1);
            chk("t1_busy", a.Busy, 1);
            chk("t1_done_low", a.Done, 0);
            chk("t1_notready", a.In_Ready, 0);
            cyc();
        end
        chk("t1_gap_out", a.Out, 8'h00);
        chk("t1_done", a.Done, 1);
        chk("t1_gap_busy", a.Busy, 1);
        chk("t1_gap_ready", a.In_Ready, 0);
        cyc();
        chk("t1_done_clr", a.Done, 0);
        chk("t1_idle_busy", a.Busy, 0);
        chk("t1_idle_ready", a.In_Ready, 1);

        // back-to-back sweep with In_Valid held
        a.In_Valid = 1;
        for (int i = 0; i < 8; i++) begin
            a.In_Code = vecs[i].code;
            #1;
            n = 0;
            while (!a.In_Ready && n < 20) begin
                cyc();
                n++;
            end
            chk("sweep_wait", n, (i == 0) ? 0 : 2);
            cyc();
            if (i == 7) a.In_Valid = 0;
            for (int k = 0; k < 4; k++) begin
                chk("sweep_out", a.Out, vecs[i].exp_out);
                chk("sweep_bits", bits_a(), vecs[i].exp_out);
                chk("sweep_onehot", $onehot(a.Out), 1);
                if (k < 3) cyc();
            end
        end
        repeat (2) cyc();
        chk("sweep_end_ready", a.In_Ready, 1);

        // minimal pulse, no gap
        b.In_Code = 3'd3; b.In_Valid = 1;
        #1 chk("b_ready", b.In_Ready, 1);
        cyc();
        b.In_Valid = 0;
        chk("b_out", b.Out, 8'h08);
        chk("b_busy", b.Busy, 1);
        chk("b_done_low", b.Done, 0);
        chk("b_notready", b.In_Ready, 0);
        cyc();
        chk("b_out_clr", b.Out, 8'h00);
        chk("b_done", b.Done, 1);
        chk("b_busy_clr", b.Busy, 0);
        chk("b_ready_again", b.In_Ready, 1);
        cyc();
        chk("b_done_clr", b.Done, 0);

        // abort on the second DRIVE cycle of code 7
        a.In_Code = 3'd7; a.In_Valid = 1;
        cyc();
        a.In_Valid = 0;
        chk("ab_out1", a.Out, 8'h80);
        cyc();
        chk("ab_out2", a.Out, 8'h80);
        a.Abort = 1;
        #1 chk("ab_blocks_ready", a.In_Ready, 0);
        cyc();
        a.Abort = 0;
        #1;
        chk("ab_out", a.Out, 8'h00);
        chk("ab_busy", a.Busy, 0);
        chk("ab_done", a.Done, 0);
        chk("ab_ready", a.In_Ready, 1);
        cyc();
        chk("ab_no_done", a.Done, 0);
        a.Abort = 1; a.In_Code = 3'd1; a.In_Valid = 1;
        #1 chk("ab_idle_ready", a.In_Ready, 0);
        cyc();
        a.Abort = 0; a.In_Valid = 0;
        #1;
        chk("ab_idle_out", a.Out, 8'h00);
        chk("ab_idle_busy", a.Busy, 0);

        // async reset mid-DRIVE of code 2
        a.In_Code = 3'd2; a.In_Valid = 1;
        cyc();
        a.In_Valid = 0;
        chk("rs_out", a.Out, 8'h04);
        #1 Rst_n = 0;
        #1;
        chk("rs_out_async", a.Out, 8'h00);
        chk("rs_busy_async", a.Busy, 0);
        @(negedge Clk);
        Rst_n = 1;
        #1;
        chk("rs_ready", a.In_Ready, 1);
        cyc();
        chk("rs_idle_out", a.Out, 8'h00);
        chk("rs_idle_busy", a.Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
